// File: rtl/mu0_pkg.sv
// Shared constants for the MU0 control slice: opcodes, ALU modes, mux selects,
// controller state encoding and the packed control word driven to the datapath.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] M_Y   = 2'b00;
  localparam logic [1:0] M_ADD = 2'b01;
  localparam logic [1:0] M_INC = 2'b10;
  localparam logic [1:0] M_SUB = 2'b11;

  localparam logic SEL_ACC = 1'b0;
  localparam logic SEL_PC  = 1'b1;
  localparam logic SEL_DIN = 1'b0;
  localparam logic SEL_IR  = 1'b1;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic [1:0] m;
    logic       rd;
    logic       wr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mu0_decode.sv
// EXEC-phase decoder: maps opcode, flags and memory handshake to the control word
// plus completion, halt and illegal-opcode indications. Purely combinational.
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [3:0] f,
  input  logic       n,
  input  logic       z,
  input  logic       mem_ready,
  output ctrl_t      ctrl,
  output logic       done,
  output logic       halt,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_IDLE;
    done    = 1'b0;
    halt    = 1'b0;
    illegal = 1'b0;
    unique case (f)
      OP_LDA: begin
        ctrl.addr_sel = 1'b1;
        ctrl.rd       = 1'b1;
        ctrl.y_sel    = SEL_DIN;
        ctrl.m        = M_Y;
        ctrl.acc_en   = mem_ready;
        done          = mem_ready;
      end
      OP_STA: begin
        ctrl.addr_sel = 1'b1;
        ctrl.x_sel    = SEL_ACC;
        ctrl.wr       = 1'b1;
        done          = mem_ready;
      end
      OP_ADD, OP_SUB: begin
        ctrl.addr_sel = 1'b1;
        ctrl.rd       = 1'b1;
        ctrl.x_sel    = SEL_ACC;
        ctrl.y_sel    = SEL_DIN;
        ctrl.m        = (f == OP_ADD) ? M_ADD : M_SUB;
        ctrl.acc_en   = mem_ready;
        done          = mem_ready;
      end
      // Jumps take the target from IR[11:0] through Y and never touch memory.
      OP_JMP, OP_JGE, OP_JNE: begin
        ctrl.y_sel = SEL_IR;
        ctrl.m     = M_Y;
        ctrl.pc_en = (f == OP_JMP) ? 1'b1 : ((f == OP_JGE) ? ~n : ~z);
        done       = 1'b1;
      end
      OP_STP: begin
        done = 1'b1;
        halt = 1'b1;
      end
      default: begin
        done    = 1'b1;
        halt    = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer with memory wait states, run gate,
// sticky illegal-opcode trap and retired-instruction counter.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  input  logic             Mem_Ready,
  input  logic             Run,
  output logic             X_sel,
  output logic             Y_sel,
  output logic             Addr_sel,
  output logic             PC_En,
  output logic             IR_En,
  output logic             Acc_En,
  output logic [1:0]       M,
  output logic             Rd,
  output logic             Wr,
  output logic             Halted,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_Count
);

  logic [1:0]       state_q, state_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  ctrl_t ctrl;
  ctrl_t dec_ctrl;
  logic  dec_done;
  logic  dec_halt;
  logic  dec_illegal;

  mu0_decode u_decode (
    .f         (F),
    .n         (N),
    .z         (Z),
    .mem_ready (Mem_Ready),
    .ctrl      (dec_ctrl),
    .done      (dec_done),
    .halt      (dec_halt),
    .illegal   (dec_illegal)
  );

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    instr_count_d = instr_count_q;
    ctrl          = CTRL_IDLE;
    unique case (state_q)
      // Fetch reads M[PC] into IR while the ALU computes PC+1; held off while Run is low.
      ST_FETCH: begin
        if (Run) begin
          ctrl.rd    = 1'b1;
          ctrl.x_sel = SEL_PC;
          ctrl.m     = M_INC;
          if (Mem_Ready) begin
            ctrl.ir_en = 1'b1;
            ctrl.pc_en = 1'b1;
            state_d    = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        ctrl = dec_ctrl;
        if (dec_done) begin
          instr_count_d = instr_count_q + CNT_W'(1);
          state_d       = dec_halt ? ST_HALT : ST_FETCH;
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_FETCH;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      illegal_q     <= illegal_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign X_sel       = ctrl.x_sel;
  assign Y_sel       = ctrl.y_sel;
  assign Addr_sel    = ctrl.addr_sel;
  assign PC_En       = ctrl.pc_en;
  assign IR_En       = ctrl.ir_en;
  assign Acc_En      = ctrl.acc_en;
  assign M           = ctrl.m;
  assign Rd          = ctrl.rd;
  assign Wr          = ctrl.wr;
  assign Halted      = halted_q;
  assign Illegal     = illegal_q;
  assign Instr_Count = instr_count_q;

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Control unit for the MU0 processor. It sits directly upstream of the MU0 datapath and drives its mux selects, register enables and ALU mode.
- It is a FETCH/EXECUTE/HALT state machine that decodes the opcode F and the flags N and Z returned by the datapath.
- It adds a memory ready handshake (wait states), a run/pause gate, an illegal-opcode trap and a retired-instruction counter.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- F  input  4  opcode, which is IR[15:12] from the datapath.
- N  input  1  accumulator negative flag.
- Z  input  1  accumulator zero flag.
- Mem_Ready  input  1  memory has completed the current Rd/Wr this cycle.
- Run  input  1  when 1, fetches are allowed; when 0, the core pauses at the next fetch boundary.
- X_sel  output  1  0 = Acc, 1 = PC.
- Y_sel  output  1  0 = Din, 1 = IR.
- Addr_sel  output  1  0 = PC, 1 = IR[11:0].
- PC_En  output  1  PC register load enable.
- IR_En  output  1  IR register load enable.
- Acc_En  output  1  Acc register load enable.
- M  output  2  ALU mode: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X-Y.
- Rd  output  1  memory read request.
- Wr  output  1  memory write request.
- Halted  output  1  core is stopped by STP or by an illegal opcode.
- Illegal  output  1  sticky flag; set when F >= 8 is executed.
- Instr_Count  output  CNT_W  number of instructions that have completed execution.

Behaviour:
- Reset (synchronous, active-high): state <= FETCH, Halted = 0, Illegal = 0, Instr_Count = 0. Reset overrides everything, including a reset arriving mid-stall or while in HALT.
- All outputs except the registered Halted, Illegal and Instr_Count are combinational from the current state, F, N, Z, Mem_Ready and Run.
- Default output values: every enable, Rd and Wr = 0; X_sel = 0; Y_sel = 0; Addr_sel = 0; M = 00.
- FETCH state:
  - If Run = 0: drive defaults, stay in FETCH, issue no memory request.
  - If Run = 1: Addr_sel = 0, Rd = 1, X_sel = 1, M = 10. When Mem_Ready = 1, also assert IR_En = 1 and PC_En = 1, then go to EXEC.
  - If Run = 1 and Mem_Ready = 0: Rd stays asserted, all enables stay at 0, state remains FETCH (wait state).
- EXEC state, decoded on F:
  - 0 LDA: Addr_sel = 1, Rd = 1, Y_sel = 0, M = 00; Acc_En = Mem_Ready.
  - 1 STA: Addr_sel = 1, X_sel = 0, Wr = 1. Wr is held until Mem_Ready = 1.
  - 2 ADD: Addr_sel = 1, Rd = 1, X_sel = 0, Y_sel = 0, M = 01; Acc_En = Mem_Ready.
  - 3 SUB: same as ADD but M = 11.
  - 4 JMP: Y_sel = 1, M = 00, PC_En = 1. No memory access; completes in 1 cycle.
  - 5 JGE: as JMP but PC_En = ~N.
  - 6 JNE: as JMP but PC_En = ~Z.
  - 7 STP: no enables; next state is HALT.
  - 8 to 15: no enables; set Illegal <= 1; next state is HALT.
- EXEC completion and counting:
  - Memory instructions (LDA, STA, ADD, SUB) stay in EXEC while Mem_Ready = 0, with Rd/Wr held and no enables.
  - On completion, go to FETCH and increment Instr_Count by 1.
  - STP and illegal opcodes also increment Instr_Count.
  - Instr_Count wraps modulo 2^CNT_W.
- HALT state: Halted = 1, all outputs at default, no memory requests. HALT is left only by Reset; Run has no effect.
- Latency: 2 cycles per instruction with zero wait states. Each cycle of Mem_Ready = 0 adds 1 cycle to any memory phase.
- Timing contract:
  - Mem_Ready is sampled only while Rd or Wr is asserted; when neither is asserted it is ignored.
  - Rd and Wr are never asserted together.
  - At most one of IR_En and Acc_En is high in a given cycle.
- Run deasserted during EXEC: the current instruction completes, then the core holds in FETCH.

Decomposition:
- Package mu0_pkg holds:
  - opcode constants OP_LDA through OP_STP;
  - ALU mode constants M_Y, M_ADD, M_INC, M_SUB;
  - mux select constants SEL_ACC, SEL_PC, SEL_DIN, SEL_IR;
  - state encoding for FETCH, EXEC and HALT.
- One sub-module, mu0_decode: a purely combinational map from (F, N, Z, Mem_Ready) to the EXEC-phase control word. The mu0_control module itself owns the state register, the stall logic, Illegal and Instr_Count.

Test Plan:
- Reset, then Run = 1 and Mem_Ready tied to 1, F = 0 (LDA) -> cycle 1: Rd = 1, IR_En = 1, PC_En = 1, M = 10, X_sel = 1. Cycle 2: Addr_sel = 1, Acc_En = 1, M = 00. Instr_Count = 1 after cycle 2.
- F = 5 (JGE): with N = 1 -> PC_En = 0 in EXEC; with N = 0 -> PC_En = 1, Y_sel = 1, M = 00. F = 6 (JNE) with Z = 1 -> PC_En = 0.
- F = 1 (STA) with Mem_Ready low for 3 cycles -> Wr = 1 with X_sel = 0 and Addr_sel = 1 held for 4 EXEC cycles. No enables are asserted. FETCH begins in the cycle after Mem_Ready rises, and Instr_Count increments once.
- F = 7 (STP) -> Halted = 1 from the next cycle. Rd, Wr and all enables stay 0 for 10+ cycles with Run = 1. Reset -> Halted = 0, state FETCH.
- F = 4'hA -> Illegal = 1 and Halted = 1. Instr_Count increments. Reset clears both flags.
- Run = 0 in FETCH -> Rd = 0 and no enables for 5 cycles. Raise Run -> fetch proceeds normally. Run dropped mid-EXEC of ADD -> ADD completes, then the core idles in FETCH.
